// File: rtl/uart_rx_param.sv
// uart_rx_param: oversampled UART receiver with configurable data width, oversampling ratio,
// optional parity, majority-vote sampling, false-start rejection and frame/parity/overrun status.
`default_nettype none

module uart_rx_param #(
   parameter int DATA_W = 8,
   parameter int OVS    = 16
) (
   input  logic              clk_uart,
   input  logic              rst_n,
   input  logic              rxd,
   input  logic              ren,
   input  logic              parity_en,
   input  logic              parity_odd,
   input  logic              rxd_int_in,
   output logic [DATA_W-1:0] r_data,
   output logic              rxd_int,
   output logic              frame_err,
   output logic              parity_err,
   output logic              overrun
);

   localparam int TW = $clog2(OVS);
   localparam int BW = (DATA_W > 1) ? $clog2(DATA_W) : 1;

   localparam logic [TW-1:0] T_S0   = TW'(OVS/2 - 1);
   localparam logic [TW-1:0] T_S1   = TW'(OVS/2);
   localparam logic [TW-1:0] T_DEC  = TW'(OVS/2 + 1);
   localparam logic [TW-1:0] T_LAST = TW'(OVS - 1);
   localparam logic [BW-1:0] B_LAST = BW'(DATA_W - 1);

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      START = 3'd1,
      DATA  = 3'd2,
      PAR   = 3'd3,
      STOP  = 3'd4
   } state_t;

   state_t            state;
   logic              sync1;
   logic              rxs;
   logic              rxs_prev;
   logic [TW-1:0]     tick;
   logic [BW-1:0]     bit_cnt;
   logic [DATA_W-1:0] shift;
   logic              s0;
   logic              s1;
   logic              par_bad;
   logic              rx_done;

   logic              maj;
   logic              decide;
   logic              fall;

   // Two-flop synchroniser plus the previous sample for falling-edge detection.
   always_ff @(posedge clk_uart or negedge rst_n) begin
      if (!rst_n) begin
         sync1    <= 1'b1;
         rxs      <= 1'b1;
         rxs_prev <= 1'b1;
      end else begin
         sync1    <= rxd;
         rxs      <= sync1;
         rxs_prev <= rxs;
      end
   end

   // Third vote is the live sample at the decision tick.
   assign maj    = (s0 & s1) | (s0 & rxs) | (s1 & rxs);
   assign decide = (tick == T_DEC);
   assign fall   = rxs_prev & ~rxs;

   always_ff @(posedge clk_uart or negedge rst_n) begin
      if (!rst_n) begin
         state      <= IDLE;
         tick       <= '0;
         bit_cnt    <= '0;
         shift      <= '0;
         s0         <= 1'b0;
         s1         <= 1'b0;
         par_bad    <= 1'b0;
         rx_done    <= 1'b0;
         r_data     <= '0;
         frame_err  <= 1'b0;
         parity_err <= 1'b0;
         overrun    <= 1'b0;
      end else begin
         rx_done <= 1'b0;
         if (state != IDLE) begin
            tick <= (tick == T_LAST) ? '0 : tick + 1'b1;
            if (tick == T_S0) s0 <= rxs;
            if (tick == T_S1) s1 <= rxs;
         end
         if (!ren) begin
            state <= IDLE;
         end else begin
            case (state)
               IDLE: begin
                  if (fall) begin
                     state <= START;
                     tick  <= '0;
                  end
               end
               START: begin
                  if (decide && maj) begin
                     state <= IDLE;
                  end else if (tick == T_LAST) begin
                     state   <= DATA;
                     bit_cnt <= '0;
                  end
               end
               DATA: begin
                  if (decide) shift <= {maj, shift[DATA_W-1:1]};
                  if (tick == T_LAST) begin
                     if (bit_cnt == B_LAST) state <= parity_en ? PAR : STOP;
                     else bit_cnt <= bit_cnt + 1'b1;
                  end
               end
               PAR: begin
                  if (decide) par_bad <= ((^shift) ^ maj) != parity_odd;
                  if (tick == T_LAST) state <= STOP;
               end
               STOP: begin
                  // Complete at mid stop bit so back-to-back frames resynchronise.
                  if (decide) begin
                     state <= IDLE;
                     if (!rxd_int_in) begin
                        r_data     <= shift;
                        frame_err  <= ~maj;
                        parity_err <= parity_en & par_bad;
                        overrun    <= 1'b0;
                        rx_done    <= 1'b1;
                     end else begin
                        overrun    <= 1'b1;
                     end
                  end
               end
               default: state <= IDLE;
            endcase
         end
      end
   end

   assign rxd_int = rxd_int_in | rx_done;

endmodule

`default_nettype wire

// File: tb/tb_uart_rx_param.sv
// tb_uart_rx_param: table-driven frames plus directed corner sequences for uart_rx_param
// (8-bit/16x instance and a 9-bit/8x instance).
`default_nettype none

module tb_uart_rx_param;

   logic       clk_uart = 1'b0;
   logic       rst_n    = 1'b0;
   logic       rxd8     = 1'b1;
   logic       rxd9     = 1'b1;
   logic       ren8     = 1'b1;
   logic       pen8     = 1'b0;
   logic       podd8    = 1'b0;
   logic       int_in8  = 1'b0;
   logic [7:0] r_data8;
   logic       rxd_int8, fe8, pe8, ov8;
   logic [8:0] r_data9;
   logic       rxd_int9, fe9, pe9, ov9;

   int n_checks = 0;
   int n_fail   = 0;
   int cyc      = 0;
   logic int_low_seen = 1'b0;

   typedef struct {
      int         cyc;
      logic [8:0] data;
      logic       fe;
      logic       pe;
      logic       ov;
   } pulse_t;
   pulse_t q8[$];
   pulse_t q9[$];

   typedef struct {
      logic [7:0] data;
      logic       pen;
      logic       podd;
      logic       pbit;
      int         gap;
      logic       exp_pe;
      int         lat;
   } vec_t;
   vec_t tv[8];
   int   tv_c0[8];

   uart_rx_param #(.DATA_W(8), .OVS(16)) dut8 (
      .clk_uart   (clk_uart),
      .rst_n      (rst_n),
      .rxd        (rxd8),
      .ren        (ren8),
      .parity_en  (pen8),
      .parity_odd (podd8),
      .rxd_int_in (int_in8),
      .r_data     (r_data8),
      .rxd_int    (rxd_int8),
      .frame_err  (fe8),
      .parity_err (pe8),
      .overrun    (ov8)
   );

   uart_rx_param #(.DATA_W(9), .OVS(8)) dut9 (
      .clk_uart   (clk_uart),
      .rst_n      (rst_n),
      .rxd        (rxd9),
      .ren        (1'b1),
      .parity_en  (1'b0),
      .parity_odd (1'b0),
      .rxd_int_in (1'b0),
      .r_data     (r_data9),
      .rxd_int    (rxd_int9),
      .frame_err  (fe9),
      .parity_err (pe9),
      .overrun    (ov9)
   );

   always #5 clk_uart = ~clk_uart;
   always @(posedge clk_uart) cyc <= cyc + 1;

   // Record every completion pulse with the status visible during it.
   always @(negedge clk_uart) begin
      if (rxd_int8 && !int_in8) q8.push_back('{cyc, {1'b0, r_data8}, fe8, pe8, ov8});
      if (rxd_int9) q9.push_back('{cyc, r_data9, fe9, pe9, ov9});
      if (int_in8 && !rxd_int8) int_low_seen = 1'b1;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   task automatic step(input int n);
      repeat (n) begin
         @(posedge clk_uart);
         #1;
      end
   endtask

   task automatic drive(input int sel, input logic b, input int n);
      if (sel == 0) rxd8 = b;
      else rxd9 = b;
      step(n);
   endtask

   task automatic send_frame(input int sel, input logic [8:0] d, input int nb, input int ovs,
                             input logic pen, input logic pbit, input logic stp, output int c0);
      c0 = cyc;
      drive(sel, 1'b0, ovs);
      for (int i = 0; i < nb; i++) drive(sel, d[i], ovs);
      if (pen) drive(sel, pbit, ovs);
      drive(sel, stp, ovs);
   endtask

   task automatic expect_pulse(input int sel, input string tag, input int exp_cyc,
                               input logic [8:0] ed, input logic efe, input logic epe,
                               input logic eov);
      pulse_t p;
      if ((sel == 0 && q8.size() == 0) || (sel == 1 && q9.size() == 0)) begin
         n_checks++;
         n_fail++;
         $display("FAIL %s pulse: got none, expected one at cycle %0d", tag, exp_cyc);
      end else begin
         p = (sel == 0) ? q8.pop_front() : q9.pop_front();
         check({tag, " cycle"}, p.cyc, exp_cyc);
         check({tag, " data"}, {23'd0, p.data}, {23'd0, ed});
         check({tag, " frame_err"}, {31'd0, p.fe}, {31'd0, efe});
         check({tag, " parity_err"}, {31'd0, p.pe}, {31'd0, epe});
         check({tag, " overrun"}, {31'd0, p.ov}, {31'd0, eov});
      end
   endtask

   initial begin
      int c0, c1;

      //          data   pen   podd  pbit  gap exp_pe lat
      tv[0] = '{8'h5C, 1'b0, 1'b0, 1'b0, 4,  1'b0, 154};
      tv[1] = '{8'h3A, 1'b0, 1'b0, 1'b0, 0,  1'b0, 154};
      tv[2] = '{8'hFF, 1'b0, 1'b0, 1'b0, 0,  1'b0, 154};
      tv[3] = '{8'h3A, 1'b1, 1'b1, 1'b1, 10, 1'b0, 170};
      tv[4] = '{8'h3A, 1'b1, 1'b1, 1'b0, 0,  1'b1, 170};
      tv[5] = '{8'hC3, 1'b1, 1'b0, 1'b0, 0,  1'b0, 170};
      tv[6] = '{8'h07, 1'b1, 1'b0, 1'b0, 0,  1'b1, 170};
      tv[7] = '{8'h5C, 1'b0, 1'b0, 1'b0, 0,  1'b0, 154};

      @(posedge clk_uart);
      #1;
      step(3);
      check("reset r_data", {24'd0, r_data8}, 32'h0);
      check("reset rxd_int", {31'd0, rxd_int8}, 32'h0);
      check("reset frame_err", {31'd0, fe8}, 32'h0);
      check("reset parity_err", {31'd0, pe8}, 32'h0);
      check("reset overrun", {31'd0, ov8}, 32'h0);
      rst_n = 1'b1;
      step(5);

      // Table-driven frames: back-to-back plain frames, then parity frames.
      for (int i = 0; i < 8; i++) begin
         pen8  = tv[i].pen;
         podd8 = tv[i].podd;
         drive(0, 1'b1, tv[i].gap);
         send_frame(0, {1'b0, tv[i].data}, 8, 16, tv[i].pen, tv[i].pbit, 1'b1, tv_c0[i]);
      end
      step(20);
      pen8 = 1'b0;
      podd8 = 1'b0;
      check("table pulse count", q8.size(), 8);
      for (int i = 0; i < 8; i++)
         expect_pulse(0, $sformatf("vec%0d", i), tv_c0[i] + 3 + tv[i].lat,
                      {1'b0, tv[i].data}, 1'b0, tv[i].exp_pe, 1'b0);
      q8.delete();

      // Reset in the middle of DATA, then a clean frame.
      drive(0, 1'b0, 64);
      rst_n = 1'b0;
      rxd8  = 1'b1;
      step(3);
      check("mid-frame reset r_data", {24'd0, r_data8}, 32'h0);
      rst_n = 1'b1;
      step(200);
      check("aborted frame pulses", q8.size(), 0);
      check("aborted frame r_data", {24'd0, r_data8}, 32'h0);
      send_frame(0, 9'h0A5, 8, 16, 1'b0, 1'b0, 1'b1, c0);
      step(10);
      expect_pulse(0, "after reset A5", c0 + 157, 9'h0A5, 1'b0, 1'b0, 1'b0);

      // Overrun while the interrupt flag is still set.
      int_in8 = 1'b1;
      int_low_seen = 1'b0;
      step(2);
      send_frame(0, 9'h011, 8, 16, 1'b0, 1'b0, 1'b1, c0);
      step(5);
      check("overrun after 11", {31'd0, ov8}, 32'h1);
      send_frame(0, 9'h022, 8, 16, 1'b0, 1'b0, 1'b1, c0);
      step(10);
      check("overrun r_data held", {24'd0, r_data8}, 32'hA5);
      check("overrun flag", {31'd0, ov8}, 32'h1);
      check("overrun rxd_int held", {31'd0, int_low_seen}, 32'h0);
      int_in8 = 1'b0;
      step(3);
      check("rxd_int after clear", {31'd0, rxd_int8}, 32'h0);
      check("overrun no pulses", q8.size(), 0);
      send_frame(0, 9'h033, 8, 16, 1'b0, 1'b0, 1'b1, c0);
      step(10);
      expect_pulse(0, "post-overrun 33", c0 + 157, 9'h033, 1'b0, 1'b0, 1'b0);

      // Short glitch is rejected as a false start.
      drive(0, 1'b0, 4);
      drive(0, 1'b1, 200);
      check("glitch pulses", q8.size(), 0);

      // Framing error, line then held low.
      send_frame(0, 9'h081, 8, 16, 1'b0, 1'b0, 1'b0, c0);
      drive(0, 1'b0, 300);
      check("framing pulse count", q8.size(), 1);
      expect_pulse(0, "framing 81", c0 + 157, 9'h081, 1'b1, 1'b0, 1'b0);
      check("framing r_data", {24'd0, r_data8}, 32'h81);
      drive(0, 1'b1, 20);
      send_frame(0, 9'h05C, 8, 16, 1'b0, 1'b0, 1'b1, c0);
      step(10);
      check("after low line pulse count", q8.size(), 1);
      expect_pulse(0, "after low 5C", c0 + 157, 9'h05C, 1'b0, 1'b0, 1'b0);

      // Receive enable dropped mid-DATA aborts the frame.
      fork
         send_frame(0, 9'h042, 8, 16, 1'b0, 1'b0, 1'b1, c1);
         begin
            step(80);
            ren8 = 1'b0;
         end
      join
      step(20);
      ren8 = 1'b1;
      step(10);
      check("ren abort pulses", q8.size(), 0);
      check("ren abort r_data", {24'd0, r_data8}, 32'h5C);
      send_frame(0, 9'h024, 8, 16, 1'b0, 1'b0, 1'b1, c0);
      step(10);
      expect_pulse(0, "ren restart 24", c0 + 157, 9'h024, 1'b0, 1'b0, 1'b0);

      // 9-bit / 8x instance, back-to-back frames.
      check("dut9 idle pulses", q9.size(), 0);
      send_frame(1, 9'h1A5, 9, 8, 1'b0, 1'b0, 1'b1, c0);
      send_frame(1, 9'h05A, 9, 8, 1'b0, 1'b0, 1'b1, c1);
      step(20);
      check("dut9 pulse count", q9.size(), 2);
      expect_pulse(1, "w9 1A5", c0 + 89, 9'h1A5, 1'b0, 1'b0, 1'b0);
      expect_pulse(1, "w9 05A", c1 + 89, 9'h05A, 1'b0, 1'b0, 1'b0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/uart_rx_param.md
Name: uart_rx_param

Overview:
- Parametrised successor to the 8051 serial-port receiver. Oversampled asynchronous receiver with configurable data width and oversampling ratio.
- Adds runtime options: receive enable, optional even/odd parity, majority-vote bit sampling, false-start rejection, and framing/parity/overrun status.
- Sits between the rxd pad and the SFR block. The SFR block owns the interrupt flag register, feeds it back as rxd_int_in, and registers the next-state value rxd_int.

Parameters:
- DATA_W, 8: data bits per frame; legal 5..9.
- OVS, 16: clk_uart cycles per bit; legal even values >= 8.

Ports:
- clk_uart  in  1  oversampling clock, OVS x baud.
- rst_n  in  1  asynchronous active-low reset.
- rxd  in  1  serial line, asynchronous, idle high.
- ren  in  1  receive enable.
- parity_en  in  1  a parity bit follows the data bits.
- parity_odd  in  1  1 = odd parity, 0 = even; ignored when parity_en=0.
- rxd_int_in  in  1  current receive-interrupt flag from the SFR register.
- r_data  out  DATA_W  last accepted frame data, LSB = first received bit.
- rxd_int  out  1  next value of the interrupt flag.
- frame_err  out  1  stop bit of the last accepted frame sampled 0.
- parity_err  out  1  parity mismatch in the last accepted frame.
- overrun  out  1  a frame completed while rxd_int_in=1.

Behaviour:
- Reset: all flops clear asynchronously.
  - Synchroniser flops and the edge-detect previous sample reset to 1.
  - FSM resets to IDLE.
  - r_data, frame_err, parity_err, overrun and rx_done all reset to 0.
- Reset mid-frame aborts the frame; nothing is loaded.
- rxd passes through a 2-flop synchroniser; rxs is the synchronised value. All decisions use rxs.
- Bit timing: a tick counter runs 0..OVS-1 per bit.
  - Samples are taken at ticks OVS/2-1, OVS/2 and OVS/2+1.
  - The bit value is the majority of the 3 samples, decided at tick OVS/2+1.
- FSM states: IDLE, START, DATA, PAR, STOP.
  - IDLE: on an rxs 1->0 transition with ren=1, go to START with tick=0 in that cycle. A line held low never retriggers.
  - START: at the decision tick, a majority of 1 is a false start and returns to IDLE. A majority of 0 continues; at tick OVS-1, go to DATA.
  - DATA: shift DATA_W bits LSB-first, one per bit period. After the last bit period, go to PAR if parity_en=1, else STOP.
  - PAR: capture the parity bit. Error if XOR(data, parity bit) != parity_odd.
  - STOP: at the decision tick (mid stop bit), complete the frame and go to IDLE immediately. The FSM does not wait for the end of the stop bit, so it resynchronises on back-to-back frames.
- Frame completion, registered, takes effect the cycle after the stop decision:
  - If rxd_int_in=0:
    - r_data <= shift register.
    - frame_err <= (stop bit == 0).
    - parity_err <= error if parity_en, else 0.
    - overrun <= 0.
    - rx_done <= 1 for exactly one cycle.
  - If rxd_int_in=1: r_data, frame_err and parity_err hold; overrun <= 1 (sticky until the next accepted frame); rx_done stays 0.
- rxd_int = rxd_int_in OR rx_done. This is combinational from rxd_int_in and registered rx_done.
- Latency: let T0 be the clk_uart edge at which rxs first reads 0 in IDLE. Then rx_done is high in the cycle starting at edge T0 + (1 + DATA_W + parity_en)*OVS + OVS/2 + 2.
- ren=0: FSM forced to IDLE at the next edge, which aborts any frame. Outputs hold; rx_done=0. Reception restarts on the next falling edge after ren returns to 1.
- parity_en and parity_odd must be stable while a frame is in progress; they are sampled only in PAR and at completion.
- Frame-error data is still loaded; software discards it using frame_err.

Test Plan:
1. Reset mid-frame: assert rst_n=0 during DATA of a frame, release, then send a clean 0xA5 frame. Required: no load from the aborted frame; r_data=0xA5 afterwards.
2. DATA_W=8, OVS=16, parity off, rxd_int_in tied 0: send 0x5C, 0x3A, 0xFF back-to-back with one stop bit each. Required:
   - three single-cycle rxd_int pulses;
   - r_data = 0x5C, 0x3A, 0xFF in turn;
   - frame_err = parity_err = overrun = 0;
   - each pulse at T0 + 9*16 + 8 + 2 = T0+154 cycles.
3. Parity: parity_en=1, parity_odd=1, send 0x3A with parity bit 1 (correct odd parity) -> parity_err=0. Resend with parity bit 0 -> parity_err=1, r_data=0x3A. Pulse at T0+170.
4. Overrun: hold rxd_int_in=1 (mimicking the SFR flag fed back through a register), send 0x11 then 0x22. Required: rxd_int stays 1; r_data keeps its prior value; overrun=1. Drop rxd_int_in, send 0x33: r_data=0x33, overrun=0.
5. Glitch and framing: a 4-cycle low pulse on an idle line produces no rxd_int. A frame 0x81 with its stop bit driven 0 produces r_data=0x81, frame_err=1. The line then stays low, and no further frame starts until rxd returns high and falls again.
6. ren and parameters: deassert ren at mid-DATA -> no completion. Re-run scenario 2 with DATA_W=9, OVS=8, sending 0x1A5 -> r_data=0x1A5, pulse at T0+10*8+4+2 = T0+86.
